cpu_bus_serializer: RTL and testbench

Parametrised bridge between a wide CPU memory port and a narrow pin-level bus. Each CPU transaction becomes a framed burst of lane-wide beats: address and write data out, a command beat, then, on reads, a bus turnaround and lane-wide read-data capture with wait states and a timeout. It sits between the CPU core and the chip pads. It replaces free-running frame sequencing and clock gating with a request/acknowledge handshake, so the CPU runs on `clk` and stalls on `cpu_busy`.

---
 rtl/cpu_bridge_pkg.sv | 17 +
 rtl/lane_deserializer.sv | 46 ++++
 rtl/cpu_bus_serializer.sv | 207 ++++++++++++++++++++
 tb/tb_cpu_bus_serializer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bridge_pkg.sv
// Shared types for the CPU-to-pin bus serializer: frame state encoding and
// the bit positions of the command beat.
package cpu_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StCmd,
        StTurn,
        StRdata,
        StDone
    } state_e;

    localparam int unsigned CMD_WE   = 0;
    localparam int unsigned CMD_MARK = 1;

endpackage

// File: rtl/lane_deserializer.sv
// Assembles lane-wide read beats into a CPU word, MSB lane or LSB lane first.
// o_word already includes the lane being loaded this cycle.
module lane_deserializer #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned LANE_W       = 8,
    parameter bit          RD_MSB_FIRST = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [LANE_W-1:0] i_lane,
    output logic [DATA_W-1:0] o_word,
    output logic              o_last
);

    localparam int unsigned DB = DATA_W / LANE_W;
    localparam int unsigned IW = (DB > 1) ? $clog2(DB) : 1;

    logic [IW-1:0]     r_idx;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] w_word;

    always_comb begin
        w_word = r_word;
        for (int unsigned i = 0; i < DB; i++) begin
            if (i_load && (r_idx == IW'(RD_MSB_FIRST ? (DB - 1 - i) : i))) begin
                w_word[i*LANE_W +: LANE_W] = i_lane;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_load) begin
            r_idx  <= r_idx + 1'b1;
            r_word <= w_word;
        end
    end

    assign o_word = w_word;
    assign o_last = i_load && (r_idx == IW'(DB - 1));

endmodule

// File: rtl/cpu_bus_serializer.sv
// Bridges a wide CPU memory port onto a narrow framed pin bus: address/data beats,
// a command beat, and for reads a turnaround plus lane-wide capture with timeout.
module cpu_bus_serializer
    import cpu_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned LANE_W       = 8,
    parameter bit          RD_MSB_FIRST = 1'b1,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_busy,
    output logic              o_cpu_ack,
    output logic              o_cpu_err,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic [LANE_W-1:0] o_pin_addr,
    output logic [LANE_W-1:0] o_pin_dout,
    input  logic [LANE_W-1:0] i_pin_din,
    output logic              o_pin_oe,
    output logic              o_pin_frame,
    input  logic              i_pin_rvalid
);

    localparam int unsigned AB = ADDR_W / LANE_W;
    localparam int unsigned DB = DATA_W / LANE_W;
    localparam int unsigned NB = (AB > DB) ? AB : DB;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    state_e            r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BW-1:0]     r_beat;
    logic [WW-1:0]     r_wait;
    logic              r_cpu_busy;
    logic              r_cpu_ack;
    logic              r_cpu_err;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [LANE_W-1:0] r_pin_addr;
    logic [LANE_W-1:0] r_pin_dout;
    logic              r_pin_oe;
    logic              r_pin_frame;

    logic                   w_src_we;
    logic [ADDR_W-1:0]      w_src_addr;
    logic [DATA_W-1:0]      w_src_wdata;
    logic [NB*LANE_W-1:0]   w_addr_pad;
    logic [NB*LANE_W-1:0]   w_data_pad;
    logic [BW-1:0]          w_next_beat;
    logic [LANE_W-1:0]      w_addr_lane;
    logic [LANE_W-1:0]      w_dout_lane;
    logic [LANE_W-1:0]      w_cmd;
    logic                   w_rd_clear;
    logic                   w_rd_load;
    logic [DATA_W-1:0]      w_rd_word;
    logic                   w_rd_last;

    // Outputs are registered, so lanes are computed for the beat about to be shown;
    // in IDLE that is beat 0 taken straight from the CPU inputs being captured.
    always_comb begin
        w_src_we    = (r_state == StIdle) ? i_cpu_we : r_we;
        w_src_addr  = (r_state == StIdle) ? i_cpu_addr : r_addr;
        w_src_wdata = (r_state == StIdle) ? i_cpu_wdata : r_wdata;
        w_next_beat = (r_state == StIdle) ? '0 : r_beat + 1'b1;
        w_addr_pad  = '0;
        w_addr_pad[ADDR_W-1:0] = w_src_addr;
        w_data_pad  = '0;
        w_data_pad[DATA_W-1:0] = w_src_wdata;
        w_addr_lane = '0;
        w_dout_lane = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            if (w_next_beat == BW'(k)) begin
                w_addr_lane = w_addr_pad[k*LANE_W +: LANE_W];
                w_dout_lane = w_src_we ? w_data_pad[k*LANE_W +: LANE_W] : '0;
            end
        end
        w_cmd           = '0;
        w_cmd[CMD_MARK] = 1'b1;
        w_cmd[CMD_WE]   = r_we;
    end

    assign w_rd_clear = (r_state == StTurn);
    assign w_rd_load  = (r_state == StRdata) && i_pin_rvalid;

    lane_deserializer #(
        .DATA_W       (DATA_W),
        .LANE_W       (LANE_W),
        .RD_MSB_FIRST (RD_MSB_FIRST)
    ) u_deser (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_rd_clear),
        .i_load  (w_rd_load),
        .i_lane  (i_pin_din),
        .o_word  (w_rd_word),
        .o_last  (w_rd_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_beat      <= '0;
            r_wait      <= '0;
            r_cpu_busy  <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_cpu_rdata <= '0;
            r_pin_addr  <= '0;
            r_pin_dout  <= '0;
            r_pin_oe    <= 1'b0;
            r_pin_frame <= 1'b0;
        end else begin
            r_cpu_ack <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_cpu_req) begin
                        r_we        <= i_cpu_we;
                        r_addr      <= i_cpu_addr;
                        r_wdata     <= i_cpu_wdata;
                        r_beat      <= '0;
                        r_state     <= StAddr;
                        r_cpu_busy  <= 1'b1;
                        r_cpu_err   <= 1'b0;
                        r_pin_frame <= 1'b1;
                        r_pin_oe    <= 1'b1;
                        r_pin_addr  <= w_addr_lane;
                        r_pin_dout  <= w_dout_lane;
                    end
                end
                StAddr: begin
                    if (r_beat == BW'(NB - 1)) begin
                        r_state    <= StCmd;
                        r_pin_addr <= w_cmd;
                        r_pin_dout <= '0;
                    end else begin
                        r_beat     <= w_next_beat;
                        r_pin_addr <= w_addr_lane;
                        r_pin_dout <= w_dout_lane;
                    end
                end
                StCmd: begin
                    r_pin_oe   <= 1'b0;
                    r_pin_addr <= '0;
                    r_pin_dout <= '0;
                    if (r_we) begin
                        r_state     <= StDone;
                        r_cpu_ack   <= 1'b1;
                        r_cpu_err   <= 1'b0;
                        r_pin_frame <= 1'b0;
                    end else begin
                        r_state <= StTurn;
                    end
                end
                StTurn: begin
                    r_state <= StRdata;
                    r_wait  <= '0;
                end
                StRdata: begin
                    if (i_pin_rvalid) begin
                        r_wait <= '0;
                        if (w_rd_last) begin
                            r_state     <= StDone;
                            r_cpu_ack   <= 1'b1;
                            r_cpu_err   <= 1'b0;
                            r_cpu_rdata <= w_rd_word;
                            r_pin_frame <= 1'b0;
                        end
                    end else if (r_wait == WW'(TIMEOUT - 1)) begin
                        // Timed out: rdata deliberately keeps the last good read.
                        r_state     <= StDone;
                        r_cpu_ack   <= 1'b1;
                        r_cpu_err   <= 1'b1;
                        r_pin_frame <= 1'b0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                StDone: begin
                    r_state    <= StIdle;
                    r_cpu_busy <= 1'b0;
                    r_cpu_err  <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_cpu_busy  = r_cpu_busy;
    assign o_cpu_ack   = r_cpu_ack;
    assign o_cpu_err   = r_cpu_err;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_pin_addr  = r_pin_addr;
    assign o_pin_dout  = r_pin_dout;
    assign o_pin_oe    = r_pin_oe;
    assign o_pin_frame = r_pin_frame;

endmodule

// File: tb/tb_cpu_bus_serializer.sv
// Bench for cpu_bus_serializer: a default instance and a narrow LSB-first instance
// with a short timeout, checked cycle by cycle against a frame-level model.
module tb_cpu_bus_serializer;

    typedef struct packed {
        logic        busy;
        logic        ack;
        logic        err;
        logic        oe;
        logic        frame;
        logic [7:0]  paddr;
        logic [7:0]  pdout;
        logic [63:0] rdata;
    } obs_t;

    typedef struct {
        int          sel;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] beats;
        int          gap_at;
        int          gap_len;
        bit          tmo;
        int          tmo_after;
        int          exp_lat;
        logic        exp_err;
        logic [63:0] exp_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_req, s_we, s_rvalid;
    logic [63:0] s_addr, s_wdata;
    logic [7:0]  s_din;
    int          sel;

    logic        a_busy, a_ack, a_err, a_oe, a_frame;
    logic [63:0] a_rdata;
    logic [7:0]  a_paddr, a_pdout;
    logic        b_busy, b_ack, b_err, b_oe, b_frame;
    logic [15:0] b_rdata;
    logic [7:0]  b_paddr, b_pdout;

    logic        m_busy, m_ack, m_err, m_oe, m_frame;
    logic [63:0] m_rdata;
    logic [7:0]  m_paddr, m_pdout;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] last_rd [2];

    always #5 clk = ~clk;

    cpu_bus_serializer u_a (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cpu_req    (s_req && (sel == 0)),
        .i_cpu_we     (s_we),
        .i_cpu_addr   (s_addr),
        .i_cpu_wdata  (s_wdata),
        .o_cpu_busy   (a_busy),
        .o_cpu_ack    (a_ack),
        .o_cpu_err    (a_err),
        .o_cpu_rdata  (a_rdata),
        .o_pin_addr   (a_paddr),
        .o_pin_dout   (a_pdout),
        .i_pin_din    (s_din),
        .o_pin_oe     (a_oe),
        .o_pin_frame  (a_frame),
        .i_pin_rvalid (s_rvalid)
    );

    cpu_bus_serializer #(
        .ADDR_W       (32),
        .DATA_W       (16),
        .LANE_W       (8),
        .RD_MSB_FIRST (1'b0),
        .TIMEOUT      (4)
    ) u_b (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cpu_req    (s_req && (sel == 1)),
        .i_cpu_we     (s_we),
        .i_cpu_addr   (s_addr[31:0]),
        .i_cpu_wdata  (s_wdata[15:0]),
        .o_cpu_busy   (b_busy),
        .o_cpu_ack    (b_ack),
        .o_cpu_err    (b_err),
        .o_cpu_rdata  (b_rdata),
        .o_pin_addr   (b_paddr),
        .o_pin_dout   (b_pdout),
        .i_pin_din    (s_din),
        .o_pin_oe     (b_oe),
        .o_pin_frame  (b_frame),
        .i_pin_rvalid (s_rvalid)
    );

    always_comb begin
        if (sel == 0) begin
            {m_busy, m_ack, m_err, m_oe, m_frame} = {a_busy, a_ack, a_err, a_oe, a_frame};
            {m_paddr, m_pdout, m_rdata} = {a_paddr, a_pdout, a_rdata};
        end else begin
            {m_busy, m_ack, m_err, m_oe, m_frame} = {b_busy, b_ack, b_err, b_oe, b_frame};
            {m_paddr, m_pdout, m_rdata} = {b_paddr, b_pdout, 48'h0, b_rdata};
        end
    end

    task automatic check(input obs_t exp, input string name, input int idx);
        obs_t got;
        got = {m_busy, m_ack, m_err, m_oe, m_frame, m_paddr, m_pdout, m_rdata};
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] dut%0d: got busy=%b ack=%b err=%b oe=%b frame=%b addr=%h dout=%h rdata=%h, want busy=%b ack=%b err=%b oe=%b frame=%b addr=%h dout=%h rdata=%h",
                     name, idx, sel, got.busy, got.ack, got.err, got.oe, got.frame, got.paddr,
                     got.pdout, got.rdata, exp.busy, exp.ack, exp.err, exp.oe, exp.frame,
                     exp.paddr, exp.pdout, exp.rdata);
        end
    endtask

    // Builds the expected per-cycle trace of a whole frame, then drives and compares it.
    task automatic run_txn(input vec_t v, input string name);
        obs_t        q[$];
        logic        qv[$];
        logic [7:0]  qd[$];
        obs_t        e;
        logic [7:0]  b;
        logic [63:0] new_rd, ack_rd;
        logic        ack_err;
        int          ab, db, nb, to, nrd, ack_cyc;
        bit          msb;
        ab  = (v.sel == 1) ? 4 : 8;
        db  = (v.sel == 1) ? 2 : 8;
        to  = (v.sel == 1) ? 4 : 255;
        msb = (v.sel == 0);
        nb  = (ab > db) ? ab : db;
        e = '0;
        e.busy = 1'b1; e.frame = 1'b1; e.oe = 1'b1; e.rdata = last_rd[v.sel];
        for (int k = 0; k < nb; k++) begin
            e.paddr = (k < ab) ? 8'(v.addr >> (8 * k)) : 8'h00;
            e.pdout = (v.we && k < db) ? 8'(v.wdata >> (8 * k)) : 8'h00;
            q.push_back(e); qv.push_back(1'b0); qd.push_back(8'($urandom));
        end
        e.paddr = {6'b0, 1'b1, v.we}; e.pdout = 8'h00;
        q.push_back(e); qv.push_back(1'b0); qd.push_back(8'($urandom));
        new_rd = last_rd[v.sel];
        if (!v.we) begin
            e.oe = 1'b0; e.paddr = 8'h00;
            q.push_back(e); qv.push_back(1'b1); qd.push_back(8'($urandom));
            nrd = v.tmo ? v.tmo_after : db;
            new_rd = '0;
            for (int i = 0; i < nrd; i++) begin
                if (i == v.gap_at) begin
                    for (int g = 0; g < v.gap_len; g++) begin
                        q.push_back(e); qv.push_back(1'b0); qd.push_back(8'($urandom));
                    end
                end
                b = 8'(v.beats >> (8 * i));
                q.push_back(e); qv.push_back(1'b1); qd.push_back(b);
                if (msb) new_rd = (new_rd << 8) | 64'(b);
                else     new_rd = new_rd | (64'(b) << (8 * i));
            end
            if (v.tmo) begin
                for (int g = 0; g < to; g++) begin
                    q.push_back(e); qv.push_back(1'b0); qd.push_back(8'($urandom));
                end
                new_rd = last_rd[v.sel];
            end
        end
        e = '0;
        e.busy = 1'b1; e.ack = 1'b1; e.err = v.tmo; e.rdata = new_rd;
        q.push_back(e); qv.push_back(1'b1); qd.push_back(8'($urandom));
        e.busy = 1'b0; e.ack = 1'b0; e.err = 1'b0;
        q.push_back(e); qv.push_back(1'b1); qd.push_back(8'($urandom));
        last_rd[v.sel] = new_rd;

        sel = v.sel; s_we = v.we; s_addr = v.addr; s_wdata = v.wdata;
        s_req = 1'b1; s_rvalid = 1'b0;
        @(posedge clk); #1;
        ack_cyc = -1; ack_rd = '0; ack_err = 1'b0;
        for (int c = 0; c < q.size(); c++) begin
            // Request and CPU inputs churn while busy; the DUT must ignore them.
            s_req    = (c == q.size() - 1) ? 1'b0 : 1'($urandom);
            s_we     = 1'($urandom);
            s_addr   = {$urandom, $urandom};
            s_wdata  = {$urandom, $urandom};
            s_rvalid = qv[c];
            s_din    = qd[c];
            @(negedge clk);
            check(q[c], name, c);
            if (m_ack && ack_cyc < 0) begin
                ack_cyc = c + 1; ack_rd = m_rdata; ack_err = m_err;
            end
            @(posedge clk); #1;
        end
        s_req = 1'b0; s_rvalid = 1'b0;
        n_checks++;
        if (v.exp_lat >= 0) begin
            if (ack_cyc != v.exp_lat || ack_err !== v.exp_err || ack_rd !== v.exp_rd) begin
                n_errors++;
                $display("FAIL %s_ack: got cycle=%0d err=%b rdata=%h, want cycle=%0d err=%b rdata=%h",
                         name, ack_cyc, ack_err, ack_rd, v.exp_lat, v.exp_err, v.exp_rd);
            end
        end else if (ack_cyc != q.size() - 1) begin
            n_errors++;
            $display("FAIL %s_ack: got cycle=%0d, want cycle=%0d", name, ack_cyc, q.size() - 1);
        end
    endtask

    vec_t tab [8];
    vec_t rv;
    obs_t z;

    initial begin
        rst = 1'b1; s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
        s_din = '0; s_rvalid = 1'b0; sel = 0;
        last_rd[0] = '0; last_rd[1] = '0;
        tab[0] = '{0, 1'b1, 64'h0123456789ABCDEF, 64'hFEEDFACECAFEBEEF, 64'h0, -1, 0, 1'b0, 0,
                   10, 1'b0, 64'h0};
        tab[1] = '{0, 1'b0, 64'h0000000000001000, 64'h0, 64'h8877665544332211, -1, 0, 1'b0, 0,
                   19, 1'b0, 64'h1122334455667788};
        tab[2] = '{0, 1'b0, 64'h0000000000002000, 64'h0, 64'h8877665544332211, 4, 3, 1'b0, 0,
                   22, 1'b0, 64'h1122334455667788};
        tab[3] = '{1, 1'b1, 64'h0000000089ABCDEF, 64'h000000000000BEEF, 64'h0, -1, 0, 1'b0, 0,
                   6, 1'b0, 64'h0};
        tab[4] = '{1, 1'b0, 64'h0000000000000040, 64'h0, 64'h0000000000002211, -1, 0, 1'b0, 0,
                   9, 1'b0, 64'h2211};
        tab[5] = '{1, 1'b0, 64'h0000000000000044, 64'h0, 64'h0, -1, 0, 1'b1, 0,
                   11, 1'b1, 64'h2211};
        tab[6] = '{1, 1'b0, 64'h0000000000000048, 64'h0, 64'h0000000000000077, -1, 0, 1'b1, 1,
                   12, 1'b1, 64'h2211};
        tab[7] = '{1, 1'b0, 64'h000000000000004C, 64'h0, 64'h0000000000004433, 1, 3, 1'b0, 0,
                   12, 1'b0, 64'h4433};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        z = '0;
        @(negedge clk);
        sel = 0; #1 check(z, "reset_a", 0);
        sel = 1; #1 check(z, "reset_b", 0);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_txn(tab[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 24; i++) begin
            rv.sel     = int'($urandom_range(0, 1));
            rv.we      = 1'($urandom);
            rv.addr    = {$urandom, $urandom};
            rv.wdata   = {$urandom, $urandom};
            rv.beats   = {$urandom, $urandom};
            rv.gap_at  = int'($urandom_range(0, (rv.sel == 1) ? 1 : 7));
            rv.gap_len = int'($urandom_range(0, 2));
            rv.tmo     = (rv.sel == 1) && !rv.we && ($urandom_range(0, 3) == 0);
            rv.tmo_after = int'($urandom_range(0, 1));
            rv.exp_lat = -1; rv.exp_err = 1'b0; rv.exp_rd = '0;
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        // Reset during ADDR beat 3 of a default-instance write.
        sel = 0; s_we = 1'b1; s_addr = 64'h0123456789ABCDEF; s_wdata = 64'hFEEDFACECAFEBEEF;
        s_req = 1'b1;
        @(posedge clk); #1 s_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        z = '0;
        z.busy = 1'b1; z.frame = 1'b1; z.oe = 1'b1; z.paddr = 8'h89; z.pdout = 8'hCA;
        z.rdata = last_rd[0];
        check(z, "rst_beat3", 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0;
        z = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check(z, "rst_abort", c);
        end
        sel = 1; #1 check(z, "rst_abort_b", 0);
        @(posedge clk); #1;
        run_txn(tab[1], "after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
